// File: rtl/instr_encoder.sv
// FPGC4 instruction packer: encodes one field set per handshake and streams
// the words to consecutive instruction-memory addresses over a we/ack port.
module instr_encoder #(
  parameter int MAX_WORDS   = 1024,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [26:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [3:0]  instrOP,
  input  logic [3:0]  opcode,
  input  logic [10:0] const11,
  input  logic [15:0] const16,
  input  logic [26:0] const27,
  input  logic [3:0]  areg,
  input  logic [3:0]  breg,
  input  logic [3:0]  dreg,
  input  logic        he,
  input  logic        oe,
  output logic [26:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        busy,
  output logic [15:0] word_count,
  output logic        full,
  output logic        err_timeout
);

  // state   | meaning
  // S_IDLE  | no session, waiting for start
  // S_READY | session open, accepting a field set
  // S_WRITE | mem_we asserted, waiting for mem_ack or timeout
  // S_FULL  | MAX_WORDS written, waiting for start
  // S_ERROR | ack timeout, waiting for start
  typedef enum logic [2:0] {S_IDLE, S_READY, S_WRITE, S_FULL, S_ERROR} state_t;

  localparam int              TW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMR_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [15:0]     CNT_MAX  = 16'(MAX_WORDS);

  state_t        state_q, state_d;
  logic [26:0]   addr_q, addr_d;
  logic [26:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic          mem_we_q, mem_we_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [31:0]   enc_word;
  logic [15:0]   cnt_inc;
  logic [26:0]   addr_inc;

  always_comb begin
    enc_word        = '0;
    enc_word[31:28] = instrOP;
    case (fmt)
      2'd0, 2'd1: begin
        enc_word[27]    = fmt[0];
        enc_word[26:23] = opcode;
        if (fmt[0]) enc_word[22:12] = const11;
        enc_word[11:8]  = areg;
        enc_word[7:4]   = breg;
        enc_word[3:0]   = dreg;
      end
      2'd2: begin
        enc_word[27:12] = const16;
        enc_word[11:9]  = areg[3:1];
        enc_word[8]     = he;
        enc_word[7:4]   = breg;
        enc_word[3:0]   = dreg;
      end
      default: begin
        enc_word[27:1] = const27;
        enc_word[0]    = oe;
      end
    endcase
  end

  assign cnt_inc  = cnt_q + 16'd1;
  assign addr_inc = addr_q + 27'd1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = mem_we_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    case (state_q)
      S_IDLE, S_FULL, S_ERROR: begin
        if (start) begin
          state_d = S_READY;
          addr_d  = base_addr;
          cnt_d   = '0;
        end
      end
      S_READY: begin
        // start outranks a simultaneous field set
        if (start) begin
          addr_d = base_addr;
          cnt_d  = '0;
        end else if (in_valid) begin
          state_d    = S_WRITE;
          mem_data_d = enc_word;
          mem_addr_d = addr_q;
          mem_we_d   = 1'b1;
          tmr_d      = TMR_LOAD;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          mem_we_d   = 1'b0;
          addr_d     = addr_inc;
          mem_addr_d = addr_inc;
          cnt_d      = cnt_inc;
          state_d    = (cnt_inc == CNT_MAX) ? S_FULL : S_READY;
        end else if (tmr_q == '0) begin
          mem_we_d = 1'b0;
          state_d  = S_ERROR;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      cnt_q      <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
    end
  end

  assign in_ready    = (state_q == S_READY);
  assign busy        = (state_q != S_IDLE);
  assign full        = (state_q == S_FULL);
  assign err_timeout = (state_q == S_ERROR);
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_we      = mem_we_q;
  assign word_count  = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table vectors, directed corner sequences and
// randomized writes checked against an arithmetic encoding model.
module tb_instr_encoder;

  localparam int MAXW   = 3;
  localparam int ACK_TO = 6;

  typedef struct {
    logic [1:0]  fmt;
    logic [3:0]  iop;
    logic [3:0]  aop;
    logic [10:0] c11;
    logic [15:0] c16;
    logic [26:0] c27;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  d;
    logic        h;
    logic        o;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn, start, in_valid, in_ready, he, oe, mem_we, mem_ack;
  logic        busy, full, err_timeout;
  logic [26:0] base_addr, const27, mem_addr;
  logic [1:0]  fmt;
  logic [3:0]  instrOP, opcode, areg, breg, dreg;
  logic [10:0] const11;
  logic [15:0] const16, word_count;
  logic [31:0] mem_data;

  int          tests = 0;
  int          fails = 0;
  logic [26:0] m_addr;
  int          m_cnt;

  always #5 clk = ~clk;

  instr_encoder #(.MAX_WORDS(MAXW), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .instrOP(instrOP),
    .opcode(opcode), .const11(const11), .const16(const16), .const27(const27),
    .areg(areg), .breg(breg), .dreg(dreg), .he(he), .oe(oe),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
    .busy(busy), .word_count(word_count), .full(full), .err_timeout(err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_enc(input vec_t v);
    longint w;
    w = longint'(v.iop) * 268435456;
    case (v.fmt)
      2'd0, 2'd1: begin
        w += longint'(v.aop) * 8388608 + longint'(v.a) * 256 + longint'(v.b) * 16 + longint'(v.d);
        if (v.fmt == 2'd1) w += 134217728 + longint'(v.c11) * 4096;
      end
      2'd2: w += longint'(v.c16) * 4096 + longint'(v.a / 4'd2) * 512 + longint'(v.h) * 256
                 + longint'(v.b) * 16 + longint'(v.d);
      default: w += longint'(v.c27) * 2 + longint'(v.o);
    endcase
    return w[31:0];
  endfunction

  task automatic drive_fields(input vec_t v);
    fmt = v.fmt; instrOP = v.iop; opcode = v.aop; const11 = v.c11; const16 = v.c16;
    const27 = v.c27; areg = v.a; breg = v.b; dreg = v.d; he = v.h; oe = v.o;
  endtask

  task automatic start_session(input logic [26:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    m_addr = base;
    m_cnt = 0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_count", 32'(word_count), 32'd0);
    check("start_flags", {30'd0, full, err_timeout}, 32'd0);
  endtask

  // Accept one field set, hold off ack for 'delay' cycles, then ack.
  task automatic write_one(input vec_t v, input int delay, input logic [31:0] exp_data);
    check("pre_ready", 32'(in_ready), 32'd1);
    drive_fields(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("acc_we", 32'(mem_we), 32'd1);
    check("acc_data", mem_data, exp_data);
    check("acc_addr", 32'(mem_addr), 32'(m_addr));
    for (int k = 0; k < delay; k++) begin
      tick();
      check("stall_we", 32'(mem_we), 32'd1);
      check("stall_data", mem_data, exp_data);
      check("stall_addr", 32'(mem_addr), 32'(m_addr));
      check("stall_ready", 32'(in_ready), 32'd0);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    m_addr = m_addr + 27'd1;
    m_cnt++;
    check("ack_we", 32'(mem_we), 32'd0);
    check("ack_count", 32'(word_count), 32'(m_cnt));
    check("ack_addr", 32'(mem_addr), 32'(m_addr));
    check("ack_ready", 32'(in_ready), (m_cnt < MAXW) ? 32'd1 : 32'd0);
    check("ack_full", 32'(full), (m_cnt == MAXW) ? 32'd1 : 32'd0);
    check("ack_err", 32'(err_timeout), 32'd0);
  endtask

  vec_t tbl[6];
  vec_t v;
  int   we_cycles;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd3, 4'd9, 4'hF, 11'h123, 16'hFFFF, 27'd5,         4'hA, 4'hB, 4'hC, 1'b1, 1'b1, 32'h9000000B};
    tbl[1] = '{2'd0, 4'd0, 4'd4, 11'h555, 16'h1234, 27'h7FFFFFF,   4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 32'h02000123};
    tbl[2] = '{2'd1, 4'd0, 4'd4, 11'h7FF, 16'h1234, 27'd3,         4'd1, 4'd2, 4'd3, 1'b0, 1'b1, 32'h0A7FF123};
    tbl[3] = '{2'd2, 4'd2, 4'hF, 11'h7FF, 16'hABCD, 27'h7FFFFFF,   4'd5, 4'd6, 4'd7, 1'b1, 1'b1, 32'h2ABCD567};
    tbl[4] = '{2'd1, 4'hF, 4'hF, 11'h7FF, 16'h0,    27'd0,         4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 32'hFFFFFFFF};
    tbl[5] = '{2'd3, 4'd0, 4'hF, 11'h7FF, 16'hFFFF, 27'h7FFFFFF,   4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 32'h0FFFFFFE};

    resetn = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0; base_addr = '0;
    drive_fields(tbl[0]);
    repeat (3) tick();
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", mem_data, 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_ctrl", {27'd0, busy, in_ready, mem_we, full, err_timeout}, 32'd0);
    resetn = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'd0);

    // format vectors, consecutive addresses from 0x100, restart when full
    start_session(27'h100);
    for (int i = 0; i < 6; i++) begin
      if (m_cnt == MAXW) start_session(m_addr);
      write_one(tbl[i], 0, tbl[i].exp);
    end

    // handshake stall
    start_session(27'h400);
    write_one(tbl[3], 5, tbl[3].exp);

    // capacity: fourth set never accepted
    start_session(27'h500);
    for (int i = 0; i < 3; i++) write_one(tbl[i], 1, tbl[i].exp);
    drive_fields(tbl[4]);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("full_no_we", 32'(mem_we), 32'd0);
      check("full_ready", 32'(in_ready), 32'd0);
      check("full_flag", 32'(full), 32'd1);
    end
    in_valid = 1'b0;
    check("full_count", 32'(word_count), 32'd3);
    start_session(27'h510);

    // timeout with no ack
    start_session(27'h600);
    drive_fields(tbl[1]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    we_cycles = 0;
    while (mem_we === 1'b1 && we_cycles < 20) begin
      we_cycles++;
      tick();
    end
    check("to_we_cycles", 32'(we_cycles), 32'(ACK_TO));
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_busy", 32'(busy), 32'd1);
    check("to_ready", 32'(in_ready), 32'd0);
    check("to_count", 32'(word_count), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("late_ack_count", 32'(word_count), 32'd0);
    check("late_ack_err", 32'(err_timeout), 32'd1);
    // ack on the last allowed cycle completes normally
    start_session(27'h610);
    write_one(tbl[2], ACK_TO - 1, tbl[2].exp);

    // address wrap
    start_session(27'h7FFFFFF);
    write_one(tbl[0], 0, tbl[0].exp);
    check("wrap_addr", 32'(mem_addr), 32'd0);
    write_one(tbl[1], 2, tbl[1].exp);

    // reset in the middle of a write, ack arriving on the same edge
    start_session(27'h700);
    drive_fields(tbl[3]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid_we", 32'(mem_we), 32'd1);
    resetn = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_data", mem_data, 32'd0);
    check("mrst_count", 32'(word_count), 32'd0);
    check("mrst_ctrl", {27'd0, busy, in_ready, mem_we, full, err_timeout}, 32'd0);
    resetn = 1'b1;
    tick();

    // start beats a simultaneous field set
    start_session(27'h800);
    write_one(tbl[1], 0, tbl[1].exp);
    drive_fields(tbl[2]);
    start = 1'b1;
    in_valid = 1'b1;
    base_addr = 27'h900;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    m_addr = 27'h900;
    m_cnt = 0;
    check("sv_we", 32'(mem_we), 32'd0);
    check("sv_count", 32'(word_count), 32'd0);
    check("sv_ready", 32'(in_ready), 32'd1);
    tick();
    check("sv_we2", 32'(mem_we), 32'd0);
    write_one(tbl[4], 1, tbl[4].exp);

    // randomized traffic against the arithmetic model
    for (int it = 0; it < 60; it++) begin
      if (m_cnt == MAXW || $urandom_range(0, 5) == 0)
        start_session(($urandom_range(0, 3) == 0) ? 27'h7FFFFFE : 27'($urandom));
      v.fmt = 2'($urandom);   v.iop = 4'($urandom);  v.aop = 4'($urandom);
      v.c11 = 11'($urandom);  v.c16 = 16'($urandom); v.c27 = 27'($urandom);
      v.a = 4'($urandom);     v.b = 4'($urandom);    v.d = 4'($urandom);
      v.h = 1'($urandom);     v.o = 1'($urandom);    v.exp = '0;
      write_one(v, int'($urandom_range(0, ACK_TO - 1)), model_enc(v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
